clock_disp_fmt: RTL and testbench
=================================

# clock_disp_fmt

Display formatter for the perpetual clock. It sits between `Perpetual_Clock` and `mfe_led7seg_74hc595_controller_wrapper`. It takes the binary calendar/time fields and periodically converts them to decimal with one shared sequential binary-to-BCD engine. It then packs a TIME or DATE frame of 7-segment glyphs and presents it with a one-cycle valid strobe. Mode is selected by a debounced button with auto-revert and a switch override; digit count, segment polarity and all timing constants are parametrised.

## Interface

Parameters:
- `DIG_NUM`, 8: number of digits; must be ≥ 8. Digits above the 8 layout digits are blank (MSB side).
- `SEG_NUM`, 8: bits per digit; fixed layout uses bit 7 as DP.
- `ACTIVE_LOW`, 1: 1 = glyph constants as-is (0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99, 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90, dash = BF, blank = FF); 0 = every glyph bitwise inverted.
- `REFRESH_DIV`, 62500000: cycles between periodic frame starts; must be ≥ 64.
- `DEBOUNCE_CYCLES`, 1250000: cycles `btn` must be stable before acceptance; must be ≥ 2.
- `HOLD_CYCLES`, 625000000: DATE_HOLD duration in cycles.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `btn` in 1: raw push-button, asynchronous.
- `sw0` in 1: raw switch, asynchronous; 1 forces DATE.
- `year` in 14: binary year.
- `mon`, `day`, `hour`, `min`, `sec` in 7 each: binary fields.
- `dat` out `DIG_NUM*SEG_NUM`: frame; digit 0 is in the LSBs (rightmost digit).
- `vld` out 1: one-cycle strobe, high in the cycle `dat` takes a new frame.
- `mode` out 1: 0 = TIME frame, 1 = DATE frame (current mode state).

## Operation

Input conditioning:
- `btn` and `sw0` each pass through a 2-flop synchroniser.
- `btn` debounce: a counter restarts on any change of the synchronised level. The debounced level takes the new value when the count reaches `DEBOUNCE_CYCLES`.
- `press` is a 1-cycle pulse on the debounced 0→1 edge.

Mode FSM (TIME, DATE_SW, DATE_HOLD):
- Any state with synchronised `sw0` = 1 → DATE_SW. This takes priority over `press`, and the hold counter is cleared.
- DATE_SW with `sw0` = 0 → TIME.
- TIME with `press` → DATE_HOLD; hold counter cleared.
- DATE_HOLD with `press` → TIME.
- DATE_HOLD when the hold counter reaches `HOLD_CYCLES` − 1 → TIME.
- `mode` = 1 in DATE_SW and DATE_HOLD.
- Every `mode` change sets a pending-refresh flag.

Frame engine FSM (IDLE, SNAP, LOAD, SHIFT, PACK):
- IDLE → SNAP when the refresh counter wraps (at `REFRESH_DIV` − 1) or the pending flag is set. Entering SNAP clears the pending flag and restarts the refresh counter.
- SNAP (1 cycle): register all six fields and `mode`. A mode change during a frame affects only the next frame (pending stays set).
- Field order: TIME = hour, min, sec; DATE = day, mon, year.
- Each field: LOAD (1 cycle), then SHIFT for 14 cycles. The engine is a double-dabble on a 14-bit operand giving 4 BCD digits, with +3 adjust on digits ≥ 5 before each shift.
- PACK (1 cycle): build the frame.
- Range check per field: hour ≤ 23, min ≤ 59, sec ≤ 59, 1 ≤ day ≤ 31, 1 ≤ mon ≤ 12, year ≤ 9999. A failing field shows dash on all of its digits.
- TIME layout, digits 7..0: h1 h2 dash m1 m2 dash s1 s2.
- DATE layout, digits 7..0: d1 d2 mo1 mo2 y1 y2 y3 y4. DP is lit on d2 and mo2 (bit 7 at its active level).
- Two-digit fields use the BCD tens/ones digits; year uses all four.

## Timing

- Reset values:
  - `dat` = all digits blank (FF each when `ACTIVE_LOW` = 1, 00 when 0).
  - `vld` = 0, `mode` = 0, FSMs in IDLE/TIME, all counters 0.
  - The pending flag is set, so the first frame starts immediately after reset release.
- Frame latency: with the start condition true in cycle T, SNAP occupies T+1, the three fields occupy T+2..T+46, and PACK occupies T+47. `dat` updates and `vld` = 1 in cycle T+48; `vld` is 0 in all other cycles.
- `dat` is held stable between strobes.
- Starts are ignored while the engine is busy; the `REFRESH_DIV` ≥ 64 constraint guarantees that a periodic start never arrives while busy. A pending flag waits for IDLE.
- `btn` → `press` latency: 2 sync cycles plus `DEBOUNCE_CYCLES`, plus 1.
- Asserting `rst` mid-frame aborts the frame; `dat` returns to blank asynchronously.

## Test plan

Parameters for all scenarios: `REFRESH_DIV` = 100, `DEBOUNCE_CYCLES` = 4, `HOLD_CYCLES` = 500.

1. Reset release with hour = 13, min = 5, sec = 59 → first `vld` 48 cycles after the start; `dat[63:0]` = F9 B0 BF C0 92 BF 92 90. Subsequent `vld` strobes every 100 cycles.
2. `sw0` = 1 with day = 9, mon = 12, year = 2024 → `mode` = 1 and an immediate refresh. Frame = C0 10 F9 24 A4 C0 A4 99 (DP on d2/mo2).
3. `btn` bounced 1-0-1 at 1-cycle spacing, then held high for 10 cycles → exactly one `press`; DATE frame shown. After 500 cycles `mode` returns to 0 and a TIME frame follows. A second press inside the hold window returns to TIME early.
4. sec = 75, hour = 24 → the hour and sec digit pairs are all BF; the min digits stay valid. year = 10000 in DATE mode → four BF digits.
5. Toggle `sw0` at SNAP+3 of a frame → the current frame keeps the old layout; the next frame starts at the next IDLE with the new layout.
6. `ACTIVE_LOW` = 0, `DIG_NUM` = 10, reset → `dat` = 0. Digits 9 and 8 are always 00, and the glyphs are inverted (e.g. digit 0 = 8'h3F).

Source files
------------

// File: rtl/clock_disp_fmt_if.sv
`default_nettype none
// ============================================================================
//  Module      : clock_disp_fmt_if
//  Description : Bundle of the display formatter's functional signals.
//                The calendar source and the raw button/switch drive the
//                inputs. The formatter returns the packed 7-segment frame,
//                its one-cycle valid strobe and the current display mode.
//  Ports       : none. The modports carry the signals below.
//                btn, sw0              raw asynchronous button / switch
//                year[13:0]            binary year
//                mon, day, hour,
//                min, sec [6:0]        binary calendar/time fields
//                dat[DIG_NUM*SEG_NUM]  frame, digit 0 in the LSBs
//                vld                   one-cycle new-frame strobe
//                mode                  0 = TIME, 1 = DATE
//  Revision    : 1.0 - initial release
// ============================================================================
interface clock_disp_fmt_if #(
    parameter int DIG_NUM = 8,
    parameter int SEG_NUM = 8
);
    logic                         btn;
    logic                         sw0;
    logic [13:0]                  year;
    logic [6:0]                   mon;
    logic [6:0]                   day;
    logic [6:0]                   hour;
    logic [6:0]                   min;
    logic [6:0]                   sec;
    logic [DIG_NUM*SEG_NUM-1:0]   dat;
    logic                         vld;
    logic                         mode;

    modport master (
        output btn, sw0, year, mon, day, hour, min, sec,
        input  dat, vld, mode
    );

    modport slave (
        input  btn, sw0, year, mon, day, hour, min, sec,
        output dat, vld, mode
    );
endinterface
`default_nettype wire

// File: rtl/clock_disp_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : clock_disp_fmt
//  Description : Display formatter for the perpetual clock. Conditions the
//                mode button and the date switch, runs the TIME/DATE mode
//                FSM, and periodically snapshots the calendar fields. Each
//                field is converted with one shared sequential double-dabble
//                engine. The result is packed into a TIME or DATE frame of
//                7-segment glyphs, presented with a one-cycle vld strobe.
//  Ports       : clk   system clock
//                rst   asynchronous active-high reset
//                bus   clock_disp_fmt_if.slave
//                      (btn, sw0, year, mon, day, hour, min, sec in;
//                       dat, vld, mode out)
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_disp_fmt #(
    parameter int DIG_NUM         = 8,
    parameter int SEG_NUM         = 8,
    parameter int ACTIVE_LOW      = 1,
    parameter int REFRESH_DIV     = 62500000,
    parameter int DEBOUNCE_CYCLES = 1250000,
    parameter int HOLD_CYCLES     = 625000000
) (
    input  logic                  clk,
    input  logic                  rst,
    clock_disp_fmt_if.slave       bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int REF_W  = $clog2(REFRESH_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [REF_W-1:0]  c_REF_MAX  = REF_W'(REFRESH_DIV - 1);
    localparam logic [DEB_W-1:0]  c_DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

    // Glyphs are held in active-low form and inverted once at the output.
    localparam logic [7:0] c_GL_DASH  = 8'hBF;
    localparam logic [7:0] c_GL_BLANK = 8'hFF;
    localparam logic [7:0] c_DP_MASK  = 8'h7F;   // clears bit 7 = DP on

    localparam logic [SEG_NUM-1:0] c_BLANK_SEG =
        (ACTIVE_LOW != 0) ? {SEG_NUM{1'b1}} : {SEG_NUM{1'b0}};
    localparam logic [DIG_NUM*SEG_NUM-1:0] c_BLANK_FRAME = {DIG_NUM{c_BLANK_SEG}};

    typedef enum logic [1:0] {
        M_TIME      = 2'd0,
        M_DATE_SW   = 2'd1,
        M_DATE_HOLD = 2'd2
    } mstate_t;

    typedef enum logic [2:0] {
        F_IDLE  = 3'd0,
        F_SNAP  = 3'd1,
        F_LOAD  = 3'd2,
        F_SHIFT = 3'd3,
        F_PACK  = 3'd4
    } fstate_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic [7:0] f_digit(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = 8'hC0;
            4'd1:    g = 8'hF9;
            4'd2:    g = 8'hA4;
            4'd3:    g = 8'hB0;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h92;
            4'd6:    g = 8'h82;
            4'd7:    g = 8'hF8;
            4'd8:    g = 8'h80;
            4'd9:    g = 8'h90;
            default: g = c_GL_BLANK;
        endcase
        return g;
    endfunction

    function automatic logic [7:0] f_pol(input logic [7:0] g);
        return (ACTIVE_LOW != 0) ? g : ~g;
    endfunction

    // One double-dabble step: +3 on every BCD digit >= 5, then shift in the
    // next binary bit. Four digits cover every legal year (<= 9999).
    function automatic logic [15:0] f_dd_step(input logic [15:0] b, input logic bit_in);
        logic [15:0] a;
        for (int k = 0; k < 4; k++) begin
            a[4*k +: 4] = (b[4*k +: 4] >= 4'd5) ? b[4*k +: 4] + 4'd3 : b[4*k +: 4];
        end
        return {a[14:0], bit_in};
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                btn_s1_q, btn_s2_q, btn_prev_q;
    logic                sw_s1_q, sw_s2_q;
    logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
    logic                deb_lvl_q, deb_lvl_d;
    logic                press_q, press_d;

    mstate_t             mstate_q, mstate_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                pend_q, pend_d;

    fstate_t             fstate_q, fstate_d;
    logic [REF_W-1:0]    ref_q, ref_d;
    logic [1:0]          fld_q, fld_d;
    logic [3:0]          sh_q, sh_d;
    logic [13:0]         bin_q, bin_d;
    logic [15:0]         bcd_q, bcd_d;
    logic [7:0]          res0_q, res0_d;
    logic [7:0]          res1_q, res1_d;
    logic [15:0]         res2_q, res2_d;
    logic [6:0]          hr_q, hr_d, mi_q, mi_d, se_q, se_d;
    logic [6:0]          dy_q, dy_d, mo_q, mo_d;
    logic [13:0]         yr_q, yr_d;
    logic                msnap_q, msnap_d;
    logic [DIG_NUM*SEG_NUM-1:0] dat_q, dat_d;
    logic                vld_q, vld_d;

    logic                w_mode_cur, w_mode_nxt;
    logic [13:0]         w_field;
    logic [15:0]         w_bcd_nxt;
    logic [7:0]          w_gl [8];
    logic                w_hr_ok, w_mi_ok, w_se_ok, w_dy_ok, w_mo_ok, w_yr_ok;
    logic [DIG_NUM*SEG_NUM-1:0] w_frame;

    // ------------------------------------------------------------------
    // Input conditioning: synchronisers, debounce, press pulse
    // ------------------------------------------------------------------
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        deb_lvl_d = deb_lvl_q;
        if (btn_s2_q != btn_prev_q) begin
            deb_cnt_d = '0;                       // level moved: restart
        end else if (btn_s2_q != deb_lvl_q) begin
            if (deb_cnt_q == c_DEB_MAX) begin
                deb_lvl_d = btn_s2_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end else begin
            deb_cnt_d = '0;
        end
        press_d = deb_lvl_d & ~deb_lvl_q;
    end

    // ------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------
    always_comb begin
        mstate_d = mstate_q;
        hold_d   = '0;
        if (sw_s2_q) begin
            mstate_d = M_DATE_SW;                 // switch beats button
        end else begin
            case (mstate_q)
                M_TIME:      if (press_q) mstate_d = M_DATE_HOLD;
                M_DATE_SW:   mstate_d = M_TIME;
                M_DATE_HOLD: begin
                    if (press_q || (hold_q == c_HOLD_MAX)) begin
                        mstate_d = M_TIME;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default:     mstate_d = M_TIME;
            endcase
        end
    end

    assign w_mode_cur = (mstate_q != M_TIME);
    assign w_mode_nxt = (mstate_d != M_TIME);

    // ------------------------------------------------------------------
    // Frame engine FSM
    // ------------------------------------------------------------------
    always_comb begin
        case (fld_q)
            2'd0:    w_field = msnap_q ? {7'd0, dy_q} : {7'd0, hr_q};
            2'd1:    w_field = msnap_q ? {7'd0, mo_q} : {7'd0, mi_q};
            default: w_field = msnap_q ? yr_q         : {7'd0, se_q};
        endcase
    end

    assign w_bcd_nxt = f_dd_step(bcd_q, bin_q[13]);

    always_comb begin
        fstate_d = fstate_q;
        ref_d    = (ref_q == c_REF_MAX) ? '0 : ref_q + 1'b1;
        pend_d   = pend_q;
        fld_d    = fld_q;
        sh_d     = sh_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        res0_d   = res0_q;
        res1_d   = res1_q;
        res2_d   = res2_q;
        hr_d     = hr_q;
        mi_d     = mi_q;
        se_d     = se_q;
        dy_d     = dy_q;
        mo_d     = mo_q;
        yr_d     = yr_q;
        msnap_d  = msnap_q;
        dat_d    = dat_q;
        vld_d    = 1'b0;
        case (fstate_q)
            F_IDLE: begin
                if ((ref_q == c_REF_MAX) || pend_q) begin
                    fstate_d = F_SNAP;
                    ref_d    = '0;
                    pend_d   = 1'b0;
                end
            end
            F_SNAP: begin
                hr_d     = bus.hour;
                mi_d     = bus.min;
                se_d     = bus.sec;
                dy_d     = bus.day;
                mo_d     = bus.mon;
                yr_d     = bus.year;
                msnap_d  = w_mode_cur;
                fld_d    = 2'd0;
                fstate_d = F_LOAD;
            end
            F_LOAD: begin
                bin_d    = w_field;
                bcd_d    = '0;
                sh_d     = '0;
                fstate_d = F_SHIFT;
            end
            F_SHIFT: begin
                bcd_d = w_bcd_nxt;
                bin_d = {bin_q[12:0], 1'b0};
                sh_d  = sh_q + 1'b1;
                if (sh_q == 4'd13) begin
                    case (fld_q)
                        2'd0:    res0_d = w_bcd_nxt[7:0];
                        2'd1:    res1_d = w_bcd_nxt[7:0];
                        default: res2_d = w_bcd_nxt;
                    endcase
                    if (fld_q == 2'd2) begin
                        fstate_d = F_PACK;
                    end else begin
                        fld_d    = fld_q + 1'b1;
                        fstate_d = F_LOAD;
                    end
                end
            end
            F_PACK: begin
                dat_d    = w_frame;
                vld_d    = 1'b1;
                fstate_d = F_IDLE;
            end
            default: fstate_d = F_IDLE;
        endcase
        // A mode change is never lost: it re-arms a refresh even mid-frame.
        if (w_mode_nxt != w_mode_cur) pend_d = 1'b1;
    end

    // ------------------------------------------------------------------
    // Frame layout (active-low glyphs, polarity applied per digit below)
    // ------------------------------------------------------------------
    always_comb begin
        w_hr_ok = (hr_q <= 7'd23);
        w_mi_ok = (mi_q <= 7'd59);
        w_se_ok = (se_q <= 7'd59);
        w_dy_ok = (dy_q >= 7'd1) && (dy_q <= 7'd31);
        w_mo_ok = (mo_q >= 7'd1) && (mo_q <= 7'd12);
        w_yr_ok = (yr_q <= 14'd9999);
        for (int k = 0; k < 8; k++) w_gl[k] = c_GL_BLANK;
        if (!msnap_q) begin
            w_gl[7] = w_hr_ok ? f_digit(res0_q[7:4]) : c_GL_DASH;
            w_gl[6] = w_hr_ok ? f_digit(res0_q[3:0]) : c_GL_DASH;
            w_gl[5] = c_GL_DASH;
            w_gl[4] = w_mi_ok ? f_digit(res1_q[7:4]) : c_GL_DASH;
            w_gl[3] = w_mi_ok ? f_digit(res1_q[3:0]) : c_GL_DASH;
            w_gl[2] = c_GL_DASH;
            w_gl[1] = w_se_ok ? f_digit(res2_q[7:4]) : c_GL_DASH;
            w_gl[0] = w_se_ok ? f_digit(res2_q[3:0]) : c_GL_DASH;
        end else begin
            w_gl[7] = w_dy_ok ? f_digit(res0_q[7:4]) : c_GL_DASH;
            w_gl[6] = (w_dy_ok ? f_digit(res0_q[3:0]) : c_GL_DASH) & c_DP_MASK;
            w_gl[5] = w_mo_ok ? f_digit(res1_q[7:4]) : c_GL_DASH;
            w_gl[4] = (w_mo_ok ? f_digit(res1_q[3:0]) : c_GL_DASH) & c_DP_MASK;
            w_gl[3] = w_yr_ok ? f_digit(res2_q[15:12]) : c_GL_DASH;
            w_gl[2] = w_yr_ok ? f_digit(res2_q[11:8])  : c_GL_DASH;
            w_gl[1] = w_yr_ok ? f_digit(res2_q[7:4])   : c_GL_DASH;
            w_gl[0] = w_yr_ok ? f_digit(res2_q[3:0])   : c_GL_DASH;
        end
    end

    // Digits beyond the eight-digit layout sit on the MSB side, always blank.
    for (genvar gi = 0; gi < DIG_NUM; gi++) begin : g_dig
        if (gi < 8) begin : g_lay
            assign w_frame[gi*SEG_NUM +: SEG_NUM] = SEG_NUM'(f_pol(w_gl[gi]));
        end else begin : g_pad
            assign w_frame[gi*SEG_NUM +: SEG_NUM] = c_BLANK_SEG;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            sw_s1_q    <= 1'b0;
            sw_s2_q    <= 1'b0;
            deb_cnt_q  <= '0;
            deb_lvl_q  <= 1'b0;
            press_q    <= 1'b0;
            mstate_q   <= M_TIME;
            hold_q     <= '0;
            pend_q     <= 1'b1;               // first frame right after reset
            fstate_q   <= F_IDLE;
            ref_q      <= '0;
            fld_q      <= '0;
            sh_q       <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            res0_q     <= '0;
            res1_q     <= '0;
            res2_q     <= '0;
            hr_q       <= '0;
            mi_q       <= '0;
            se_q       <= '0;
            dy_q       <= '0;
            mo_q       <= '0;
            yr_q       <= '0;
            msnap_q    <= 1'b0;
            dat_q      <= c_BLANK_FRAME;
            vld_q      <= 1'b0;
        end else begin
            btn_s1_q   <= bus.btn;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
            sw_s1_q    <= bus.sw0;
            sw_s2_q    <= sw_s1_q;
            deb_cnt_q  <= deb_cnt_d;
            deb_lvl_q  <= deb_lvl_d;
            press_q    <= press_d;
            mstate_q   <= mstate_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            fstate_q   <= fstate_d;
            ref_q      <= ref_d;
            fld_q      <= fld_d;
            sh_q       <= sh_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            res0_q     <= res0_d;
            res1_q     <= res1_d;
            res2_q     <= res2_d;
            hr_q       <= hr_d;
            mi_q       <= mi_d;
            se_q       <= se_d;
            dy_q       <= dy_d;
            mo_q       <= mo_d;
            yr_q       <= yr_d;
            msnap_q    <= msnap_d;
            dat_q      <= dat_d;
            vld_q      <= vld_d;
        end
    end

    assign bus.dat  = dat_q;
    assign bus.vld  = vld_q;
    assign bus.mode = w_mode_cur;

endmodule
`default_nettype wire

// File: tb/tb_clock_disp_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_disp_fmt
//  Description : Directed self-checking bench for clock_disp_fmt. One
//                instance uses the default format (8 digits, active-low
//                glyphs). A second instance uses 10 digits with inverted
//                glyphs. Both share clock, reset and inputs.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_disp_fmt;

    localparam int REF  = 100;
    localparam int DEB  = 4;
    localparam int HOLD = 500;

    localparam logic [63:0] T_13   = 64'hF9B0_BFC0_92BF_9290;
    localparam logic [63:0] D_2024 = 64'hC010_F924_A4C0_A499;
    localparam logic [63:0] T_BAD  = 64'hBFBF_BFC0_92BF_BFBF;
    localparam logic [63:0] D_BADY = 64'hC010_F924_BFBF_BFBF;
    localparam logic [79:0] A0_T13 = {16'h0000, 64'h064F_403F_6D40_6D6F};
    localparam logic [79:0] A0_D   = {16'h0000, 64'h3FEF_06DB_5B3F_5B66};

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    clock_disp_fmt_if #(.DIG_NUM(8),  .SEG_NUM(8)) bus  ();
    clock_disp_fmt_if #(.DIG_NUM(10), .SEG_NUM(8)) bus2 ();

    assign bus2.btn  = bus.btn;
    assign bus2.sw0  = bus.sw0;
    assign bus2.year = bus.year;
    assign bus2.mon  = bus.mon;
    assign bus2.day  = bus.day;
    assign bus2.hour = bus.hour;
    assign bus2.min  = bus.min;
    assign bus2.sec  = bus.sec;

    clock_disp_fmt #(
        .DIG_NUM(8), .SEG_NUM(8), .ACTIVE_LOW(1),
        .REFRESH_DIV(REF), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    clock_disp_fmt #(
        .DIG_NUM(10), .SEG_NUM(8), .ACTIVE_LOW(0),
        .REFRESH_DIV(REF), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)
    ) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    // Returns the number of negedges until vld is seen, or -1 on timeout.
    task automatic wait_vld(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus.vld) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        bus.btn = 1'b0; bus.sw0 = 1'b0;
        bus.hour = 7'd13; bus.min = 7'd5; bus.sec = 7'd59;
        bus.day = 7'd9; bus.mon = 7'd12; bus.year = 14'd2024;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.dat !== 64'hFFFF_FFFF_FFFF_FFFF || bus.vld !== 1'b0 || bus.mode !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: dat=%h vld=%b mode=%b, want ffffffffffffffff/0/0",
                     bus.dat, bus.vld, bus.mode);
        end
        n_cmp++;
        if (bus2.dat !== 80'h0) begin
            n_bad++; $display("FAIL reset_inv: dat=%h want 0", bus2.dat);
        end
        rst = 1'b0;
        wait_vld(60, n);
        n_cmp++;
        if (n !== 48) begin
            n_bad++; $display("FAIL first_latency: got %0d want 48", n);
        end
        n_cmp++;
        if (bus.dat !== T_13) begin
            n_bad++; $display("FAIL time_frame: got %h want %h", bus.dat, T_13);
        end
        n_cmp++;
        if (bus2.dat !== A0_T13) begin
            n_bad++; $display("FAIL inv_time_frame: got %h want %h", bus2.dat, A0_T13);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.vld !== 1'b0) begin
            n_bad++; $display("FAIL vld_width: vld=%b want 0", bus.vld);
        end
        // One negedge of the 100-cycle period is already consumed above.
        wait_vld(120, n);
        n_cmp++;
        if (n !== 99) begin
            n_bad++; $display("FAIL refresh_period: got %0d want 99", n);
        end
    endtask

    task automatic test_sw_date;
        int n;
        bus.sw0 = 1'b1;
        wait_vld(60, n);
        n_cmp++;
        if (n !== 51) begin
            n_bad++; $display("FAIL sw_latency: got %0d want 51", n);
        end
        n_cmp++;
        if (bus.mode !== 1'b1) begin
            n_bad++; $display("FAIL sw_mode: got %b want 1", bus.mode);
        end
        n_cmp++;
        if (bus.dat !== D_2024) begin
            n_bad++; $display("FAIL date_frame: got %h want %h", bus.dat, D_2024);
        end
        n_cmp++;
        if (bus2.dat !== A0_D) begin
            n_bad++; $display("FAIL inv_date_frame: got %h want %h", bus2.dat, A0_D);
        end
    endtask

    task automatic test_btn_hold;
        int n, hold_len, rises;
        logic prev, got, fell;
        logic [63:0] dframe;
        bus.sw0 = 1'b0;
        wait_vld(60, n);
        n_cmp++;
        if (n !== 51 || bus.mode !== 1'b0 || bus.dat !== T_13) begin
            n_bad++;
            $display("FAIL sw_release: lat=%0d mode=%b dat=%h want 51/0/%h", n, bus.mode, bus.dat, T_13);
        end
        hold_len = 0; rises = 0; prev = 1'b0; got = 1'b0; fell = 1'b0; dframe = '0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (bus.mode && !prev) rises++;
            if (bus.mode) hold_len++;
            if (bus.vld && bus.mode && !got) begin
                dframe = bus.dat;
                got = 1'b1;
            end
            if (!bus.mode && prev) begin
                fell = 1'b1;
                break;
            end
            prev = bus.mode;
            bus.btn = (i == 0) || (i >= 2 && i < 12);   // 1-0-1 bounce, then held
        end
        bus.btn = 1'b0;
        n_cmp++;
        if (rises !== 1 || fell !== 1'b1) begin
            n_bad++; $display("FAIL single_press: rises=%0d fell=%b want 1/1", rises, fell);
        end
        n_cmp++;
        if (hold_len !== HOLD) begin
            n_bad++; $display("FAIL hold_len: got %0d want %0d", hold_len, HOLD);
        end
        n_cmp++;
        if (got !== 1'b1 || dframe !== D_2024) begin
            n_bad++; $display("FAIL hold_date_frame: got %h want %h", dframe, D_2024);
        end
        wait_vld(150, n);
        n_cmp++;
        if (n < 0 || bus.mode !== 1'b0 || bus.dat !== T_13) begin
            n_bad++; $display("FAIL revert_frame: n=%0d mode=%b dat=%h want %h", n, bus.mode, bus.dat, T_13);
        end
    endtask

    task automatic test_btn_early;
        int hold_len;
        hold_len = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.mode) hold_len++;
            if (i > 8 && !bus.mode) break;
            bus.btn = (i < 10) || (i >= 60 && i < 70);
        end
        bus.btn = 1'b0;
        n_cmp++;
        if (hold_len !== 60 || bus.mode !== 1'b0) begin
            n_bad++; $display("FAIL early_return: hold=%0d mode=%b want 60/0", hold_len, bus.mode);
        end
    endtask

    task automatic test_range;
        int n;
        bus.hour = 7'd24; bus.sec = 7'd75;
        wait_vld(150, n);
        wait_vld(150, n);
        n_cmp++;
        if (bus.dat !== T_BAD) begin
            n_bad++; $display("FAIL time_range: got %h want %h", bus.dat, T_BAD);
        end
        bus.year = 14'd10000; bus.sw0 = 1'b1;
        wait_vld(150, n);
        wait_vld(150, n);
        n_cmp++;
        if (bus.mode !== 1'b1 || bus.dat !== D_BADY) begin
            n_bad++; $display("FAIL year_range: mode=%b got %h want %h", bus.mode, bus.dat, D_BADY);
        end
    endtask

    task automatic test_sw_mid_frame;
        int n;
        bus.year = 14'd2024; bus.hour = 7'd13; bus.sec = 7'd59;
        wait_vld(150, n);
        wait_vld(150, n);
        // Next periodic SNAP is 53 negedges after this strobe; toggle at SNAP+3.
        repeat (56) @(negedge clk);
        bus.sw0 = 1'b0;
        wait_vld(100, n);
        n_cmp++;
        if (n !== 44 || bus.dat !== D_2024) begin
            n_bad++; $display("FAIL mid_frame_old: n=%0d dat=%h want 44/%h", n, bus.dat, D_2024);
        end
        wait_vld(100, n);
        n_cmp++;
        if (n !== 48 || bus.dat !== T_13 || bus.mode !== 1'b0) begin
            n_bad++; $display("FAIL mid_frame_new: n=%0d dat=%h mode=%b want 48/%h/0", n, bus.dat, bus.mode, T_13);
        end
    endtask

    task automatic test_rst_mid;
        int n;
        bus.sw0 = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (bus.mode !== 1'b1) begin
            n_bad++; $display("FAIL pre_rst_mode: got %b want 1", bus.mode);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.dat !== 64'hFFFF_FFFF_FFFF_FFFF || bus.vld !== 1'b0 || bus.mode !== 1'b0 || bus2.dat !== 80'h0) begin
            n_bad++;
            $display("FAIL async_rst: dat=%h vld=%b mode=%b dat2=%h want blank/0/0/0",
                     bus.dat, bus.vld, bus.mode, bus2.dat);
        end
        bus.sw0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_vld(60, n);
        n_cmp++;
        if (n !== 48 || bus.dat !== T_13) begin
            n_bad++; $display("FAIL post_rst_frame: n=%0d dat=%h want 48/%h", n, bus.dat, T_13);
        end
    endtask

    initial begin
        test_reset();
        test_sw_date();
        test_btn_hold();
        test_btn_early();
        test_range();
        test_sw_mid_frame();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
